vg_host_spi: RTL and testbench
==============================

Name: vg_host_spi

Overview:
- SPI-slave host port that loads the vector RAM and controls the vector generator; sits directly upstream of the vector RAM write port and the state machine's DMA-go input.
- A host microcontroller streams display lists into vector RAM (0x000–0x3FF), starts a frame with a GO command, and polls halt status.
- All SPI pins are asynchronous and are synchronised into clk; the host's SCLK must be ≤ clk/8.

Parameters:
- ADDR_W, 10, vector RAM address width; address wraps modulo 2^ADDR_W.
- SYNC_STAGES, 2, flip-flop stages on spi_sclk, spi_mosi and spi_cs_n (minimum 2).

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high; clock clk
- spi_sclk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), async
- spi_mosi  in  1  SPI data in, MSB first, async
- spi_cs_n  in  1  SPI chip select, active low, async
- spi_miso  out  1  SPI data out; 0 whenever synchronised cs_n is high
- ram_addr  out  ADDR_W  vector RAM write address
- ram_wdata  out  8  vector RAM write data
- ram_we  out  1  one-clk write strobe
- dmago  out  1  one-clk pulse that starts a vector list at address 0
- halted_in  in  1  vector generator halted flag (haltstrobe level)
- busy  out  1  high while synchronised cs_n is low

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; err flag 0; address 0; bit counter 0.
- Edge detection on synchronised signals: sclk rise samples MOSI; sclk fall shifts MISO; cs_n fall starts a frame; cs_n rise ends it.
- byte_done pulses for 1 clk when the 8th rising edge of a frame byte has been sampled.
- Shift register: 8 bits, MSB first; bit counter resets to 0 on every cs_n fall.
- FSM states: IDLE, CMD, ADDR_HI, ADDR_LO, DATA, STAT, IGNORE.
- cs_n fall moves IDLE → CMD.
- In CMD, on byte_done, decode the command byte:
  - 0x01 → ADDR_HI.
  - 0x02 → pulse dmago exactly 1 clk, registered the cycle after byte_done; then IGNORE.
  - 0x03 → load the MISO shift register with {halted_in, err, 6'b0}; MSB appears on spi_miso the cycle after byte_done; clear err; then STAT.
  - Any other value → set err; then IGNORE.
- ADDR_HI: on byte_done, addr[9:8] ← byte[1:0]; bits [7:2] are ignored → ADDR_LO.
- ADDR_LO: on byte_done, addr[7:0] ← byte → DATA.
- DATA: each byte_done drives ram_wdata=byte and ram_addr=addr with ram_we=1 in the next clk; addr then increments. 0x3FF wraps to 0x000.
- STAT: MISO shifts on each sclk fall. After 8 bits it shifts 0s. Further bytes are ignored.
- IGNORE: consumes bytes with no side effects.
- Any state → IDLE on cs_n rise, from any bit position:
  - A partial byte is discarded; no write and no pulse occur.
  - The address is retained but is only reused after a new 0x01 command.
- Simultaneous byte_done and cs_n rise in the same clk: byte_done wins (the action is performed), then IDLE.
- reset during a frame: FSM → IDLE immediately. Writing resumes only after cs_n goes high and then falls again. A write pending in the reset cycle is dropped.
- ram_we and dmago are never high in the same cycle.
- Maximum write throughput is 1 byte per 8 sclk periods.

Test Plan:
- Reset with cs_n low mid-byte → all outputs 0; no ram_we until the next cs_n high→low frame.
- Frame 01 00 10 AA BB CC → ram_we three times: (0x010,0xAA), (0x011,0xBB), (0x012,0xCC); each ram_we exactly 1 clk wide.
- Frame 01 03 FF 11 22 → writes (0x3FF,0x11), then (0x000,0x22) (wrap).
- Frame 02 → single 1-clk dmago pulse; no ram_we. Frame 02 followed by extra bytes → still only one pulse.
- Frame 7E, then frame 03 xx with halted_in=1 → MISO returns 0xC0; an immediate second 03 frame returns 0x80 (err cleared).
- Frame 01 00 20, then 4 data bits and cs_n rise → no write. Frame 01 00 20 55 → write (0x020,0x55).

Source files
------------

// File: rtl/vg_host_spi.sv
// vg_host_spi: SPI-slave (mode 0) host port for the vector generator.
// The host streams display lists into vector RAM, issues GO to start a frame
// and reads back halt/error status.  All SPI pins are synchronised into clk;
// SCLK must run at clk/8 or slower.
module vg_host_spi #(
  parameter int ADDR_W      = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_cs_n,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  output logic              dmago,
  input  logic              halted_in,
  output logic              busy
);

  localparam logic [7:0] CMD_ADDR = 8'h01;
  localparam logic [7:0] CMD_GO   = 8'h02;
  localparam logic [7:0] CMD_STAT = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR_HI = 3'd2,
    ST_ADDR_LO = 3'd3,
    ST_DATA    = 3'd4,
    ST_STAT    = 3'd5,
    ST_IGNORE  = 3'd6
  } state_t;

  // synchronisers and edge-detect history
  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES:0]   valid_r;
  logic                   sclk_d_r;
  logic                   cs_d_r;
  logic                   armed_r;

  logic sclk_s, mosi_s, cs_s, valid_s;
  logic sclk_rise_s, sclk_fall_s, cs_fall_s, cs_rise_s, in_frame_s;

  // byte assembly
  logic [7:0] shift_r;
  logic [2:0] bit_cnt_r;
  logic       byte_done_r;

  // control
  state_t state_r, state_next_s, state_case_s;
  logic   do_write_s, do_go_s, do_stat_s, set_err_s, load_hi_s, load_lo_s;

  // datapath
  logic [ADDR_W-1:0] addr_r;
  logic              err_r;
  logic [7:0]        miso_sr_r;
  logic              miso_run_r;
  logic [ADDR_W-1:0] ram_addr_r;
  logic [7:0]        ram_wdata_r;
  logic              ram_we_r;
  logic              dmago_r;
  logic              busy_r;

  assign sclk_s  = sclk_sync_r[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync_r[SYNC_STAGES-1];
  assign cs_s    = cs_sync_r[SYNC_STAGES-1];
  // The synchronised view is trusted only once the chains have refilled after reset.
  assign valid_s = valid_r[SYNC_STAGES];

  assign sclk_rise_s = valid_s & sclk_s & ~sclk_d_r;
  assign sclk_fall_s = valid_s & ~sclk_s & sclk_d_r;
  // A frame may start only after cs_n has been seen high since reset.
  assign cs_fall_s   = armed_r & ~cs_s & cs_d_r;
  assign cs_rise_s   = valid_s & cs_s & ~cs_d_r;
  assign in_frame_s  = (state_r != ST_IDLE) & ~cs_s;

  // Synchronise the SPI pins and keep one cycle of history for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      valid_r     <= {(SYNC_STAGES+1){1'b0}};
      sclk_d_r    <= 1'b0;
      cs_d_r      <= 1'b1;
      armed_r     <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs_n};
      valid_r     <= {valid_r[SYNC_STAGES-1:0], 1'b1};
      sclk_d_r    <= sclk_s;
      cs_d_r      <= cs_s;
      if (valid_s && cs_s) begin
        armed_r <= 1'b1;
      end
    end
  end

  // Shift MOSI in MSB first on sclk rise and flag each completed byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_r     <= 8'h00;
      bit_cnt_r   <= 3'd0;
      byte_done_r <= 1'b0;
    end else begin
      byte_done_r <= 1'b0;
      if (cs_fall_s) begin
        bit_cnt_r <= 3'd0;
      end else if (sclk_rise_s && in_frame_s) begin
        shift_r     <= {shift_r[6:0], mosi_s};
        bit_cnt_r   <= bit_cnt_r + 3'd1;
        byte_done_r <= (bit_cnt_r == 3'd7);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state and per-byte actions; a completed byte is acted on even when cs_n rises in the same cycle.
  always_comb begin
    state_case_s = state_r;
    do_write_s   = 1'b0;
    do_go_s      = 1'b0;
    do_stat_s    = 1'b0;
    set_err_s    = 1'b0;
    load_hi_s    = 1'b0;
    load_lo_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cs_fall_s) begin
          state_case_s = ST_CMD;
        end else begin
          state_case_s = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (byte_done_r) begin
          case (shift_r)
            CMD_ADDR: state_case_s = ST_ADDR_HI;
            CMD_GO: begin
              do_go_s      = 1'b1;
              state_case_s = ST_IGNORE;
            end
            CMD_STAT: begin
              do_stat_s    = 1'b1;
              state_case_s = ST_STAT;
            end
            default: begin
              set_err_s    = 1'b1;
              state_case_s = ST_IGNORE;
            end
          endcase
        end else begin
          state_case_s = ST_CMD;
        end
      end
      ST_ADDR_HI: begin
        if (byte_done_r) begin
          load_hi_s    = 1'b1;
          state_case_s = ST_ADDR_LO;
        end else begin
          state_case_s = ST_ADDR_HI;
        end
      end
      ST_ADDR_LO: begin
        if (byte_done_r) begin
          load_lo_s    = 1'b1;
          state_case_s = ST_DATA;
        end else begin
          state_case_s = ST_ADDR_LO;
        end
      end
      ST_DATA: begin
        if (byte_done_r) begin
          do_write_s = 1'b1;
        end else begin
          do_write_s = 1'b0;
        end
        state_case_s = ST_DATA;
      end
      ST_STAT:   state_case_s = ST_STAT;
      ST_IGNORE: state_case_s = ST_IGNORE;
      default:   state_case_s = ST_IDLE;
    endcase
    if (cs_rise_s) begin
      state_next_s = ST_IDLE;
    end else begin
      state_next_s = state_case_s;
    end
  end

  // Address pointer, RAM write port, GO pulse and error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r      <= {ADDR_W{1'b0}};
      err_r       <= 1'b0;
      ram_addr_r  <= {ADDR_W{1'b0}};
      ram_wdata_r <= 8'h00;
      ram_we_r    <= 1'b0;
      dmago_r     <= 1'b0;
    end else begin
      ram_we_r <= do_write_s;
      dmago_r  <= do_go_s;
      if (do_write_s) begin
        ram_addr_r  <= addr_r;
        ram_wdata_r <= shift_r;
        addr_r      <= addr_r + ADDR_W'(1);
      end else if (load_hi_s) begin
        addr_r[ADDR_W-1:8] <= shift_r[ADDR_W-9:0];
      end else if (load_lo_s) begin
        addr_r[7:0] <= shift_r;
      end
      if (set_err_s) begin
        err_r <= 1'b1;
      end else if (do_stat_s) begin
        err_r <= 1'b0;
      end
    end
  end

  // Status shift-out; the fall that ends the command byte is skipped so the MSB survives until the host samples it.
  always_ff @(posedge clk) begin
    if (reset) begin
      miso_sr_r  <= 8'h00;
      miso_run_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      busy_r <= valid_s & ~cs_s;
      if (cs_s) begin
        miso_sr_r  <= 8'h00;
        miso_run_r <= 1'b0;
      end else if (do_stat_s) begin
        miso_sr_r  <= {halted_in, err_r, 6'b000000};
        miso_run_r <= 1'b0;
      end else if (state_r == ST_STAT) begin
        if (sclk_rise_s) begin
          miso_run_r <= 1'b1;
        end
        if (sclk_fall_s && miso_run_r) begin
          miso_sr_r <= {miso_sr_r[6:0], 1'b0};
        end
      end
    end
  end

  assign spi_miso  = miso_sr_r[7];
  assign ram_addr  = ram_addr_r;
  assign ram_wdata = ram_wdata_r;
  assign ram_we    = ram_we_r;
  assign dmago     = dmago_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_vg_host_spi.sv
// Bench for vg_host_spi: drives SPI mode-0 frames, keeps scoreboards of
// expected RAM writes, GO pulses and status bytes, and compares on output.
module tb_vg_host_spi;

  localparam int HALF = 8;  // clk cycles per SCLK half period (SCLK = clk/16)

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_miso;
  logic [9:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic       dmago;
  logic       halted_in = 1'b0;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [17:0] wr_q[$];
  logic        go_q[$];
  logic [7:0]  miso_q[$];
  logic        we_prev_r = 1'b0;
  logic        go_prev_r = 1'b0;

  vg_host_spi #(.ADDR_W(10), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .spi_miso(spi_miso),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .dmago(dmago), .halted_in(halted_in), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi_mosi = tx[7-i];
      tick(HALF);
      spi_sclk = 1'b1;
      rx[7-i] = spi_miso;
      tick(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    tick(HALF);
    check("busy_in_frame", 32'(busy), 32'd1);
  endtask

  task automatic cs_high();
    tick(HALF);
    spi_cs_n = 1'b1;
    tick(4*HALF);
  endtask

  // n bytes taken left-aligned from a 48-bit vector
  task automatic send_frame(input int n, input logic [47:0] bytes);
    logic [7:0] rx;
    cs_low();
    for (int k = 0; k < n; k++) spi_bits(bytes[47-8*k -: 8], 8, rx);
    cs_high();
  endtask

  task automatic stat_frame(input logic [7:0] exp);
    logic [7:0] rx;
    miso_q.push_back(exp);
    cs_low();
    spi_bits(8'h03, 8, rx);
    spi_bits(8'h00, 8, rx);
    cs_high();
    check("stat_byte", 32'(rx), 32'(miso_q.pop_front()));
  endtask

  task automatic push_wr(input logic [9:0] a, input logic [7:0] d);
    wr_q.push_back({a, d});
  endtask

  // Output monitor: pop the scoreboards whenever the DUT produces a write or GO pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (we_prev_r) check("we_width", 32'(ram_we), 32'd0);
      if (go_prev_r) check("go_width", 32'(dmago), 32'd0);
      if (ram_we) begin
        check("we_go_excl", 32'(dmago), 32'd0);
        if (wr_q.size() == 0) begin
          check("unexpected_we", 32'(ram_addr), 32'hFFFF_FFFF);
        end else begin
          check("wr_addr", 32'(ram_addr), 32'(wr_q[0][17:8]));
          check("wr_data", 32'(ram_wdata), 32'(wr_q[0][7:0]));
          void'(wr_q.pop_front());
        end
      end
      if (dmago) begin
        check("go_expected", 32'(go_q.size()), 32'd1);
        if (go_q.size() != 0) void'(go_q.pop_front());
      end
    end
    we_prev_r <= ram_we;
    go_prev_r <= dmago;
  end

  initial begin
    logic [7:0] rx;
    tick(4);
    check("rst_outputs", 32'({ram_we, dmago, busy, spi_miso, ram_addr, ram_wdata}), 32'd0);
    reset = 1'b0;
    tick(8);
    check("idle_busy", 32'(busy), 32'd0);

    // sequential writes
    push_wr(10'h010, 8'hAA); push_wr(10'h011, 8'hBB); push_wr(10'h012, 8'hCC);
    send_frame(6, 48'h01_00_10_AA_BB_CC);

    // address wrap
    push_wr(10'h3FF, 8'h11); push_wr(10'h000, 8'h22);
    send_frame(5, 48'h01_03_FF_11_22_00);

    // GO, alone and with trailing bytes
    go_q.push_back(1'b1);
    send_frame(1, 48'h02_00_00_00_00_00);
    go_q.push_back(1'b1);
    send_frame(3, 48'h02_55_66_00_00_00);

    // bad command sets err; status reads back then clears it
    send_frame(1, 48'h7E_00_00_00_00_00);
    halted_in = 1'b1;
    stat_frame(8'hC0);
    stat_frame(8'h80);
    halted_in = 1'b0;
    stat_frame(8'h00);

    // partial data byte is discarded, then a full one lands
    cs_low();
    spi_bits(8'h01, 8, rx); spi_bits(8'h00, 8, rx); spi_bits(8'h20, 8, rx);
    spi_bits(8'h55, 4, rx);
    cs_high();
    push_wr(10'h020, 8'h55);
    send_frame(4, 48'h01_00_20_55_00_00);

    // reset in the middle of a frame: nothing written until a fresh frame
    cs_low();
    spi_bits(8'h01, 8, rx); spi_bits(8'h00, 8, rx); spi_bits(8'h10, 8, rx);
    spi_bits(8'h99, 4, rx);
    reset = 1'b1;
    tick(3);
    check("rst_mid_outputs", 32'({ram_we, dmago, busy, spi_miso, ram_addr, ram_wdata}), 32'd0);
    reset = 1'b0;
    spi_bits(8'h99, 4, rx);
    spi_bits(8'h77, 8, rx);
    spi_bits(8'h02, 8, rx);
    cs_high();
    push_wr(10'h100, 8'h99);
    send_frame(4, 48'h01_01_00_99_00_00);

    tick(20);
    check("wr_q_empty", 32'(wr_q.size()), 32'd0);
    check("go_q_empty", 32'(go_q.size()), 32'd0);
    check("end_busy", 32'(busy), 32'd0);
    check("end_miso", 32'(spi_miso), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
